// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the PIC10-compatible CPU: Q-phase encoding, stack depth,
// status bit positions and the instruction decoder used by the control unit.
package cpu_control_unit_pkg;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_e;

    localparam int         STACK_DEPTH = 2;
    localparam logic [4:0] PCL_ADDR    = 5'h02;
    localparam int         STATUS_C    = 0;
    localparam int         STATUS_DC   = 1;
    localparam int         STATUS_Z    = 2;

    typedef struct packed {
        logic       f_read;
        logic       w_dest;
        logic       f_dest;
        logic       option_wr;
        logic [2:0] tris_wr;
        logic       goto_op;
        logic       call_op;
        logic       retlw_op;
        logic       skip_on_z;
        logic       skip_on_nz;
    } decode_t;

    function automatic decode_t decode(input logic [11:0] ir);
        decode_t d;
        // NOTE: every field gets a default before the case so the decode stays
        // purely combinational; a missing default here would infer latches.
        d = '0;
        casez (ir)
            12'b0000_0000_0010: d.option_wr = 1'b1;
            12'b0000_0000_0101: d.tris_wr   = 3'b001;
            12'b0000_0000_0110: d.tris_wr   = 3'b010;
            12'b0000_0000_0111: d.tris_wr   = 3'b100;
            12'b0000_001?_????: d.f_dest    = 1'b1;   // MOVWF
            12'b0000_010?_????: d.w_dest    = 1'b1;   // CLRW
            12'b0000_011?_????: d.f_dest    = 1'b1;   // CLRF
            12'b0000_1???_????,
            12'b0001_????_????,
            12'b001?_????_????: begin
                d.f_read    = 1'b1;
                d.w_dest    = ~ir[5];
                d.f_dest    = ir[5];
                d.skip_on_z = (ir[11:6] == 6'b001011) || (ir[11:6] == 6'b001111);
            end
            12'b010?_????_????: begin                 // BCF / BSF
                d.f_read = 1'b1;
                d.f_dest = 1'b1;
            end
            12'b0110_????_????: begin                 // BTFSC: Z=1 means bit clear
                d.f_read    = 1'b1;
                d.skip_on_z = 1'b1;
            end
            12'b0111_????_????: begin                 // BTFSS
                d.f_read     = 1'b1;
                d.skip_on_nz = 1'b1;
            end
            12'b1000_????_????: begin                 // RETLW
                d.w_dest   = 1'b1;
                d.retlw_op = 1'b1;
            end
            12'b1001_????_????: d.call_op = 1'b1;
            12'b101?_????_????: d.goto_op = 1'b1;
            12'b11??_????_????: d.w_dest  = 1'b1;     // MOVLW/IORLW/ANDLW/XORLW
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_control_unit_stack.sv
// Hardware return stack: push shifts entries down, pop shifts them up; overflow
// drops the oldest entry and underflow returns whatever is left.
module cpu_stack
    import cpu_control_unit_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stk_q [STACK_DEPTH];

    // NOTE: this small register array is reset like the rest of the state so a
    // pop from an empty stack after reset returns zero rather than X.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stk_q <= '{default: '0};
        end else if (push) begin
            stk_q[0] <= din;
            for (int i = 1; i < STACK_DEPTH; i++) stk_q[i] <= stk_q[i-1];
        end else if (pop) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
        end
    end

    assign dout = stk_q[0];

endmodule

// File: rtl/cpu_control_unit.sv
// Instruction sequencer: Q1-Q4 phase counter, instruction register, write-strobe
// decode, PC/stack update and forced-NOP insertion for skips and branches.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [11:0]     instr_in,
    input  logic            alu_z_in,
    input  logic            alu_c_load_in,
    input  logic            alu_dc_load_in,
    input  logic            alu_z_load_in,
    output logic [PC_W-1:0] pc_out,
    output logic [11:0]     alu_op_out,
    output logic [1:0]      phase_out,
    output logic [4:0]      f_addr_out,
    output logic            f_read_out,
    output logic            f_write_out,
    output logic            w_write_out,
    output logic            status_c_we,
    output logic            status_dc_we,
    output logic            status_z_we,
    output logic            option_write_out,
    output logic [2:0]      tris_write_out
);

    phase_e          phase_q;
    logic [PC_W-1:0] pc_q;
    logic [11:0]     ir_q;
    logic            kill_q;
    logic            kill_hold_q;

    decode_t         dec;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stack_top;
    logic            in_q4;
    logic            skip_hit;

    assign dec      = decode(ir_q);
    assign pc_inc   = pc_q + PC_W'(1);
    assign in_q4    = (phase_q == Q4);
    assign skip_hit = (dec.skip_on_z & alu_z_in) | (dec.skip_on_nz & ~alu_z_in);

    cpu_stack #(.W(PC_W)) u_stack (
        .clk    (clk),
        .resetn (resetn),
        .push   (in_q4 & dec.call_op),
        .pop    (in_q4 & dec.retlw_op),
        .din    (pc_inc),
        .dout   (stack_top)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch of the phase case sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q     <= Q1;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            kill_q      <= 1'b0;
            kill_hold_q <= 1'b0;
        end else begin
            phase_q <= phase_e'(phase_q + 2'd1);
            unique case (phase_q)
                Q1: begin
                    ir_q   <= kill_q ? 12'h000 : instr_in;
                    kill_q <= 1'b0;
                end
                Q3: begin
                    if (skip_hit) begin
                        kill_q      <= 1'b1;
                        kill_hold_q <= 1'b0;
                    end
                end
                Q4: begin
                    kill_hold_q <= 1'b0;
                    if (dec.goto_op || dec.call_op || dec.retlw_op) begin
                        kill_q      <= 1'b1;
                        kill_hold_q <= 1'b1;
                        if (dec.goto_op)      pc_q <= PC_W'(ir_q[8:0]);
                        else if (dec.call_op) pc_q <= PC_W'({1'b0, ir_q[7:0]});
                        else                  pc_q <= stack_top;
                    end else if (!kill_hold_q) begin
                        pc_q <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // A forced NOP clears ir_q, so its decode already yields no strobes.
    assign pc_out           = pc_q;
    assign alu_op_out       = ir_q;
    assign phase_out        = phase_q;
    assign f_addr_out       = ir_q[4:0];
    assign f_read_out       = dec.f_read & (phase_q == Q2);
    assign f_write_out      = dec.f_dest & in_q4;
    assign w_write_out      = dec.w_dest & in_q4;
    assign option_write_out = dec.option_wr & in_q4;
    assign tris_write_out   = dec.tris_wr & {3{in_q4}};
    assign status_c_we      = alu_c_load_in & in_q4;
    assign status_dc_we     = alu_dc_load_in & in_q4;
    assign status_z_we      = alu_z_load_in & in_q4;

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Instruction sequencer for the PIC10-compatible CPU. It fetches each 12-bit instruction, steps it through a fixed four-phase (Q1–Q4) instruction cycle, and presents it to `cpu_alu` as `alu_op_in`. It decodes the destination and side-effect strobes for W, the file register, STATUS, OPTION and TRIS. It owns the PC and the 2-level hardware stack, and it resolves skip and branch instructions by inserting a forced NOP cycle.

## Interface
Parameters
- `PC_W`, 9: program counter width (512-word program space).
- `RESET_PC`, 9'h000: PC value after reset.

Ports
- `clk`  in  1: system clock.
- `resetn`  in  1: synchronous, active-low reset.
- `instr_in`  in  12: program memory data at `pc_out`, valid whenever `pc_out` is stable.
- `alu_z_in`  in  1: `alu_status_out[STATUS_Z]` from `cpu_alu`.
- `alu_c_load_in`, `alu_dc_load_in`, `alu_z_load_in`  in  1 each: status load requests from `cpu_alu`.
- `pc_out`  out  PC_W: program memory address.
- `alu_op_out`  out  12: instruction register, driven to `cpu_alu` `alu_op_in`.
- `phase_out`  out  2: current Q phase (0=Q1 … 3=Q4).
- `f_addr_out`  out  5: equal to `ir[4:0]`.
- `f_read_out`  out  1: high in Q2 for file-operand instructions.
- `f_write_out`, `w_write_out`  out  1: write-back strobes, Q4 only.
- `status_c_we`, `status_dc_we`, `status_z_we`  out  1: equal to the ALU load requests ANDed with Q4.
- `option_write_out`  out  1: Q4 strobe.
- `tris_write_out`  out  3: one-hot Q4 strobe for TRIS 5/6/7.

## Operation
- **Phase counter:** free-running 2-bit counter, Q1→Q2→Q3→Q4→Q1. One instruction cycle is 4 clocks.
- **Q1:** `ir` ← `instr_in`, or 12'h000 (NOP) if `kill` is set; `kill` then clears.
- **Q2:** `f_read_out` is asserted for byte-oriented and bit-oriented file instructions.
- **Q3:** ALU result and flags settle; `alu_z_in` is sampled at the end of Q3.
- **Q4:** write strobes fire and PC/stack update.
- **Destination decode:**
  - Byte ops with d=`ir[5]`: d=0 → W, d=1 → f. The same rule applies to DECFSZ and INCFSZ.
  - MOVWF, CLRF, BCF, BSF → f.
  - CLRW, MOVLW, ANDLW, IORLW, XORLW, RETLW → W.
  - OPTION → `option_write_out`.
  - TRISn → `tris_write_out[n-5]`.
  - NOP, SLEEP, CLRWDT, BTFSC, BTFSS, GOTO → no write.
- **Skip:** `kill` is set with `kill_hold`=0 on any of these conditions:
  - DECFSZ or INCFSZ with Z=1;
  - BTFSC with Z=1 (bit clear);
  - BTFSS with Z=0.
- **PC update at Q4:**
  - GOTO: PC ← `ir[8:0]`.
  - CALL: push PC+1, then PC ← {1'b0, `ir[7:0]`}.
  - RETLW: pop to PC.
  - Otherwise: PC ← PC+1, except in a forced-NOP cycle with `kill_hold`=1, where PC holds.
  - GOTO, CALL and RETLW set `kill` with `kill_hold`=1, so every branch costs 8 clocks.
- **PC arithmetic:** modulo 2^PC_W; 0x1FF+1 → 0x000.
- **Stack (2 levels):**
  - Push: `s1` ← `s0`, `s0` ← value. On a third push, the oldest entry is lost silently.
  - Pop: PC ← `s0`, `s0` ← `s1`, `s1` unchanged. An empty pop returns the stale contents with no error.
- **Out of scope:** writes to PCL (f=0x02) are not redirected into the PC; computed GOTO is not supported in this block.

## Timing
- **Reset:** while `resetn`=0 at a clock edge:
  - phase=Q1, PC=`RESET_PC`, `ir`=0, `s0`=`s1`=0, `kill`=0;
  - all strobes 0.
  - Reset asserted in any phase aborts the instruction; no Q4 strobe fires afterwards.
  - The first fetch occurs at the first edge with `resetn`=1.
- **Latency:** an instruction is latched at the end of Q1 and written back at the Q4 edge. Results are visible to the next instruction's Q2.
- **Strobe width:** every write strobe is exactly 1 clock, in Q4, and is suppressed when `ir` is a forced NOP.
- **Status write enables:** combinational from the ALU load requests, so they must be gated only in Q4.
- **Simultaneous events:** a skip or branch resolving in Q4 while reset is asserted gives reset priority.

## Structure
- **Shared header `definition.vh`:**
  - already holds the opcode patterns and `STATUS_C`, `STATUS_DC`, `STATUS_Z`;
  - add phase encodings `Q1`–`Q4`, `STACK_DEPTH`=2, and the `PCL_ADDR` constant.
- **Sub-module `cpu_stack`:** a 2-entry push/pop register pair with `clk`, `resetn`, `push`, `pop`, `din[8:0]`, `dout[8:0]`.
- **Control FSM:** the phase counter, `kill`/`kill_hold` and the decode logic stay in `cpu_control_unit`.

## Test plan
- **Reset and straight-line code:** reset, then MOVLW 0x5A, ADDWF 0x10,1 → `pc_out` 0,1,2 at 4-clock intervals; `w_write_out` then `f_write_out` each 1 clock in Q4; `status_*_we` only on ADDWF.
- **GOTO:** GOTO 0x123 at PC 0x005 → PC=0x123 after Q4; the next cycle executes NOP with PC held; `instr_in`@0x123 is latched 8 clocks after the GOTO was latched.
- **Skips:**
  - DECFSZ with `alu_z_in`=1 → following instruction forced to NOP, no strobes, PC advances by 2 over 8 clocks.
  - Same with `alu_z_in`=0 → normal 4-clock flow.
- **Bit tests:** BTFSC with Z=0 → no skip; BTFSS with Z=0 → skip; BTFSS with Z=1 → no skip.
- **Stack:**
  - CALL 0x40 at PC 0x010, CALL 0x80 at 0x040, RETLW, RETLW → PC returns 0x041 then 0x011.
  - Three nested CALLs then three RETLWs → the third return repeats the second entry.
- **Reset mid-instruction and wrap:**
  - `resetn` low during Q3 of a W-write instruction → no `w_write_out`; PC=0.
  - PC at 0x1FF with NOP → PC wraps to 0x000.
